instr_fetch_stage: RTL and testbench
====================================

# instr_fetch_stage

Instruction-fetch (IF) stage and IF/ID pipeline register of the pipelined MIPS CPU. It holds the program counter, selects the current 32-bit instruction from the packed instruction image driven into the CPU, and presents `InstrD`/`PCPlus4D` to the decode stage. It obeys the stall request from the load-use hazard unit and the flush/redirect request from branch/jump resolution in decode.

## Interface
Parameters:
- `IMEM_WORDS`, 10: number of 32-bit instructions in the packed image.
- `PC_W`, 32: program counter width.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_datain`  in  32*IMEM_WORDS  packed instruction image. Word k is `i_datain[32*IMEM_WORDS-1-32k -: 32]`, at byte address 4k.
- `stall_f`  in  1  load-use stall: hold PC and IF/ID.
- `redirect`  in  1  branch taken or jump resolved in decode.
- `redirect_pc`  in  PC_W  target address for `redirect`.
- `PC`  out  PC_W  current fetch address (PCF).
- `InstrD`  out  32  IF/ID instruction register.
- `PCPlus4D`  out  PC_W  IF/ID PC+4 register.
- `valid_d`  out  1  `InstrD` holds a real fetched instruction, not a bubble.
- `done`  out  1  `PC` is beyond the image.

## Operation
- Fetch index is `idx = PC[PC_W-1:2]`. If `idx < IMEM_WORDS`, the fetched word is image word `idx`. Otherwise the fetched word is `32'h0` (sll $0 nop) and `done` = 1.
- `PC` low two bits are always 0. `redirect_pc[1:0]` is ignored and forced to 0.
- Per-edge priority: reset > redirect > stall > advance.
  - **redirect**: `PC <= {redirect_pc[PC_W-1:2],2'b00}`, `InstrD <= 0`, `PCPlus4D <= 0`, `valid_d <= 0`. This squashes the wrong-path instruction. Redirect overrides a concurrent `stall_f`.
  - **stall** (`stall_f`=1, no redirect): `PC`, `InstrD`, `PCPlus4D` and `valid_d` all hold.
  - **advance**: `InstrD <= fetched word`, `PCPlus4D <= PC+4`, `valid_d <= (idx < IMEM_WORDS)`, `PC <= PC+4`.
  - **PC saturation**: once `done`=1, `PC` stops incrementing. It stays at the first out-of-range address and nops keep entering IF/ID with `valid_d`=0. A later redirect into range resumes normal fetch.
- PC+4 wraps modulo 2^PC_W. No overflow flag.
- `done` is combinational from `PC` only.

## Timing
- Reset values: `PC`=0, `InstrD`=0, `PCPlus4D`=0, `valid_d`=0. `done`=0 when `IMEM_WORDS`>0.
- Reset asserted mid-run clears all registers immediately, without waiting for a clock edge. A pending stall or redirect is discarded.
- Latency is 1 cycle. The instruction at `PC` during cycle n appears on `InstrD` after edge n+1.
- After reset release, edge 1 gives `InstrD` = word 0, `PC`=4.
- Steady state with no hazards: `PC` advances by 4 every edge.
- Each stall cycle inserts exactly one held cycle. The decode/execute stages insert the bubble into ID/EX. This block only holds.
- `i_datain` is sampled combinationally at each edge. Changing it mid-run affects only future fetches.

## Configuration
- `FETCH_PERF_CNT_EN`: when defined, adds three 32-bit outputs, all reset to 0 and saturating at all-ones:
  - `fetch_cnt`: increments on every advance with `valid_d` next = 1.
  - `stall_cnt`: increments on every edge with `stall_f`=1 and `redirect`=0.
  - `flush_cnt`: increments on every edge with `redirect`=1.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

## Test plan
- **Reset/sequential fetch:** load six instructions (addi, sw, addi, lw, addi, sll), no stall or redirect, 8 edges -> `InstrD` follows words 0..5 in order. `PC` goes 4,8,…,24. `PCPlus4D` = 4,8,…. From the 7th edge `valid_d`=0 and `done`=1.
- **Load-use stall:** assert `stall_f` for one cycle while `InstrD`=lw (word 3) -> `InstrD` stays lw and `PC` stays 16 for that edge. The next edge gives `InstrD`=addi (word 4), with no instruction lost or duplicated.
- **Redirect:** assert `redirect` with `redirect_pc`=32'h0000_0006 while `PC`=12 -> next edge gives `PC`=4, `InstrD`=0, `valid_d`=0. The following edge gives `InstrD`=word 1.
- **Redirect + stall same cycle:** `stall_f`=1 and `redirect`=1 with target 0 -> `PC`=0 and IF/ID cleared, i.e. redirect wins.
- **Async reset mid-run:** pull `reset_n` low between edges at `PC`=20 -> `PC`, `InstrD` and `valid_d` are 0 before the next edge. After release, fetch restarts at word 0.
- **With `FETCH_PERF_CNT_EN`:** run the stall-then-redirect sequence above over 10 edges -> the three counters equal the exact number of valid fetches, stall edges and redirect edges seen.

Source files
------------

// File: rtl/instr_fetch_stage_if.sv
// Bundle between the instruction-fetch stage and the rest of the CPU.
// The slave modport is the fetch stage and the master modport is the surrounding pipeline.
// Optional feature macro: FETCH_PERF_CNT_EN adds the fetch/stall/flush counters.
interface instr_fetch_stage_if #(
    parameter int IMEM_WORDS = 10,
    parameter int PC_W       = 32
);
    logic [32*IMEM_WORDS-1:0] i_datain;
    logic                     stall_f;
    logic                     redirect;
    logic [PC_W-1:0]          redirect_pc;
    logic [PC_W-1:0]          PC;
    logic [31:0]              InstrD;
    logic [PC_W-1:0]          PCPlus4D;
    logic                     valid_d;
    logic                     done;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]              fetch_cnt;
    logic [31:0]              stall_cnt;
    logic [31:0]              flush_cnt;
`endif

    modport master (
        output i_datain, stall_f, redirect, redirect_pc,
`ifdef FETCH_PERF_CNT_EN
        input  fetch_cnt, stall_cnt, flush_cnt,
`endif
        input  PC, InstrD, PCPlus4D, valid_d, done
    );

    modport slave (
        input  i_datain, stall_f, redirect, redirect_pc,
`ifdef FETCH_PERF_CNT_EN
        output fetch_cnt, stall_cnt, flush_cnt,
`endif
        output PC, InstrD, PCPlus4D, valid_d, done
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// MIPS instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, selects the current word from the packed instruction image and
// feeds InstrD/PCPlus4D to decode. Priority per edge: reset > redirect > stall > advance.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating fetch/stall/flush counters.
module instr_fetch_stage #(
    parameter int IMEM_WORDS = 10,
    parameter int PC_W       = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    instr_fetch_stage_if.slave      bus
);
    localparam logic [PC_W-1:0] PC_STEP   = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_MSK = {{(PC_W-2){1'b1}}, 2'b00};

    logic [PC_W-1:0] pc_q,  pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc4_q, pc4_d;
    logic            vld_q, vld_d;

    logic [PC_W-1:0] idx_s;
    logic            in_range_s;
    logic [31:0]     fetched_s;
    logic [PC_W-1:0] pc_plus4_s;
    logic [PC_W-1:0] target_s;

    assign idx_s      = pc_q >> 2;
    assign in_range_s = (idx_s < PC_W'(IMEM_WORDS));
    assign pc_plus4_s = pc_q + PC_STEP;
    // Low address bits of the target are discarded so the PC stays word aligned.
    assign target_s   = bus.redirect_pc & ALIGN_MSK;

    // Select the image word addressed by the PC; out-of-range fetches yield a nop (all zero).
    always_comb begin
        fetched_s = 32'h0;
        for (int k = 0; k < IMEM_WORDS; k++) begin
            fetched_s = fetched_s |
                ((idx_s == PC_W'(k)) ? bus.i_datain[32*IMEM_WORDS-1-32*k -: 32] : 32'h0);
        end
    end

    // Next-state for PC and IF/ID: redirect squashes, stall holds, otherwise advance.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        vld_d   = vld_q;
        if (bus.redirect) begin
            pc_d    = target_s;
            instr_d = 32'h0;
            pc4_d   = '0;
            vld_d   = 1'b0;
        end else if (bus.stall_f) begin
            pc_d    = pc_q;
            instr_d = instr_q;
            pc4_d   = pc4_q;
            vld_d   = vld_q;
        end else begin
            instr_d = fetched_s;
            pc4_d   = pc_plus4_s;
            vld_d   = in_range_s;
            // PC parks on the first out-of-range address until redirected.
            pc_d    = in_range_s ? pc_plus4_s : pc_q;
        end
    end

    // PC and IF/ID register with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            instr_q <= 32'h0;
            pc4_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.PC       = pc_q;
    assign bus.InstrD   = instr_q;
    assign bus.PCPlus4D = pc4_q;
    assign bus.valid_d  = vld_q;
    assign bus.done     = ~in_range_s;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        sat_inc = (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
    endfunction

    // Counter next-state: valid advances, stall-only edges and redirect edges.
    always_comb begin
        fetch_cnt_d = sat_inc(fetch_cnt_q, !bus.redirect && !bus.stall_f && in_range_s);
        stall_cnt_d = sat_inc(stall_cnt_q, !bus.redirect && bus.stall_f);
        flush_cnt_d = sat_inc(flush_cnt_q, bus.redirect);
    end

    // Performance counter registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.fetch_cnt = fetch_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed testbench for instr_fetch_stage with a six-word program image.
// Optional feature macro: FETCH_PERF_CNT_EN also checks the performance counters.
module tb_instr_fetch_stage;
    localparam int NW = 6;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    logic [31:0] w [NW];

    instr_fetch_stage_if #(.IMEM_WORDS(NW), .PC_W(32)) bus ();

    instr_fetch_stage #(.IMEM_WORDS(NW), .PC_W(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] pc4, input logic v);
        chk({tag, ".PC"},       bus.PC,       pc);
        chk({tag, ".InstrD"},   bus.InstrD,   ins);
        chk({tag, ".PCPlus4D"}, bus.PCPlus4D, pc4);
        chk({tag, ".valid_d"},  {31'h0, bus.valid_d}, {31'h0, v});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        w[0] = 32'h2001_0005;   // addi $1,$0,5
        w[1] = 32'hAC01_0000;   // sw   $1,0($0)
        w[2] = 32'h2002_0007;   // addi $2,$0,7
        w[3] = 32'h8C03_0000;   // lw   $3,0($0)
        w[4] = 32'h2064_0001;   // addi $4,$3,1
        w[5] = 32'h0004_2880;   // sll  $5,$4,2
        bus.i_datain    = {w[0], w[1], w[2], w[3], w[4], w[5]};
        bus.stall_f     = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        reset_n         = 1'b0;

        // Reset state
        #12;
        chk_if("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rst.done", {31'h0, bus.done}, 32'h0);
        reset_n = 1'b1;

        // Sequential fetch over 8 edges, saturating past the image end
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e <= NW) begin
                chk_if($sformatf("seq%0d", e), 32'(4*e), w[e-1], 32'(4*e), 1'b1);
                chk($sformatf("seq%0d.done", e), {31'h0, bus.done}, {31'h0, (e == NW)});
            end else begin
                chk_if($sformatf("seq%0d", e), 32'd24, 32'h0, 32'd28, 1'b0);
                chk($sformatf("seq%0d.done", e), {31'h0, bus.done}, 32'h1);
            end
        end

        // Redirect and stall together: redirect wins and resumes from saturation
        bus.stall_f = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0;
        step();
        chk_if("rdst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rdst.done", {31'h0, bus.done}, 32'h0);
        bus.stall_f = 1'b0; bus.redirect = 1'b0;

        // Load-use stall while InstrD holds lw
        for (int e = 1; e <= 4; e++) step();
        chk_if("pre_stall", 32'd16, w[3], 32'd16, 1'b1);
        bus.stall_f = 1'b1;
        step();
        chk_if("stall", 32'd16, w[3], 32'd16, 1'b1);
        bus.stall_f = 1'b0;
        step();
        chk_if("post_stall", 32'd20, w[4], 32'd20, 1'b1);

        // Asynchronous reset between edges
        reset_n = 1'b0;
        #2;
        chk_if("arst", 32'h0, 32'h0, 32'h0, 1'b0);
        reset_n = 1'b1;
        step();
        chk_if("arst_rel", 32'd4, w[0], 32'd4, 1'b1);

        // Redirect from PC=12 to unaligned target 6
        step();
        step();
        chk("pre_rd.PC", bus.PC, 32'd12);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0006;
        step();
        chk_if("redir", 32'd4, 32'h0, 32'h0, 1'b0);
        bus.redirect = 1'b0;
        step();
        chk_if("post_rd", 32'd8, w[1], 32'd8, 1'b1);

        // Counter sequence: 4 fetch, stall, fetch, redirect, fetch, stall+redirect, fetch
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int e = 1; e <= 4; e++) step();
        bus.stall_f = 1'b1; step(); bus.stall_f = 1'b0;
        step();
        bus.redirect = 1'b1; bus.redirect_pc = 32'd4; step(); bus.redirect = 1'b0;
        step();
        bus.stall_f = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'd8; step();
        bus.stall_f = 1'b0; bus.redirect = 1'b0;
        step();
        chk_if("cnt_seq", 32'd12, w[2], 32'd12, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", bus.fetch_cnt, 32'd7);
        chk("stall_cnt", bus.stall_cnt, 32'd1);
        chk("flush_cnt", bus.flush_cnt, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
